// File: rtl/buffer2_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : buffer2_stream_ctrl                                            |
// | Purpose : Circular-pointer stream controller for a parallel-write /      |
// |           parallel-read line buffer. Accepts PAR_WRITE words per input   |
// |           beat, presents PAR_READ words per output beat, and tracks      |
// |           occupancy so the buffer is never overrun or read early.        |
// | Ports   : clk, rst          - clock, synchronous active-high reset       |
// |           in_valid/in_ready/in_data    - upstream valid/ready stream     |
// |           out_valid/out_ready/out_data - downstream valid/ready stream   |
// |           buf_wen/buf_waddr/buf_din    - buffer write port              |
// |           buf_raddr/buf_dout           - buffer read port               |
// |           count                        - occupancy in words            |
// |           flush (optional)             - synchronous clear             |
// | Config  : BUF2_CTRL_FLUSH_EN - when defined, adds the flush input port.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module buffer2_stream_ctrl #(
  parameter int SIZE        = 16,
  parameter int MEM_SIZE    = 8,
  parameter int PAR_WRITE   = 4,
  parameter int PAR_READ    = 2,
  parameter int ADDRES_SIZE = $clog2(MEM_SIZE),
  parameter int CNT_SIZE    = $clog2(MEM_SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef BUF2_CTRL_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SIZE*PAR_WRITE-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SIZE*PAR_READ-1:0]  out_data,
  output logic                      buf_wen,
  output logic [ADDRES_SIZE-1:0]    buf_waddr,
  output logic [SIZE*PAR_WRITE-1:0] buf_din,
  output logic [ADDRES_SIZE-1:0]    buf_raddr,
  input  logic [SIZE*PAR_READ-1:0]  buf_dout,
  output logic [CNT_SIZE-1:0]       count
);

  localparam logic [CNT_SIZE-1:0]    c_space_lim = CNT_SIZE'(MEM_SIZE - PAR_WRITE);
  localparam logic [CNT_SIZE-1:0]    c_cnt_wstep = CNT_SIZE'(PAR_WRITE);
  localparam logic [CNT_SIZE-1:0]    c_cnt_rstep = CNT_SIZE'(PAR_READ);
  // Last aligned base address of each pointer; the next step wraps to 0.
  localparam logic [ADDRES_SIZE-1:0] c_wptr_last = ADDRES_SIZE'(MEM_SIZE - PAR_WRITE);
  localparam logic [ADDRES_SIZE-1:0] c_rptr_last = ADDRES_SIZE'(MEM_SIZE - PAR_READ);
  localparam logic [ADDRES_SIZE-1:0] c_wptr_step = ADDRES_SIZE'(PAR_WRITE);
  localparam logic [ADDRES_SIZE-1:0] c_rptr_step = ADDRES_SIZE'(PAR_READ);

  logic [ADDRES_SIZE-1:0] r_wptr;
  logic [ADDRES_SIZE-1:0] r_rptr;
  logic [CNT_SIZE-1:0]    r_cnt;
  logic                   w_flush;
  logic                   w_push;
  logic                   w_pop;

`ifdef BUF2_CTRL_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Handshake flags come from registered occupancy only, so neither side's
  // ready/valid ever combinationally depends on the other side.
  assign in_ready  = ~w_flush & (r_cnt <= c_space_lim);
  assign out_valid = ~w_flush & (r_cnt >= c_cnt_rstep);

  // Reset suppresses the write strobe so no in-flight beat reaches the buffer.
  assign w_push  = in_valid & in_ready & ~rst;
  assign w_pop   = out_valid & out_ready & ~rst;
  assign buf_wen = w_push;

  assign buf_waddr = r_wptr;
  assign buf_raddr = r_rptr;
  assign buf_din   = in_data;
  assign out_data  = buf_dout;
  assign count     = r_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      // Pointers stay aligned to their step, so compare against the last
      // aligned base instead of computing a general modulo.
      if (w_push) begin
        r_wptr <= (r_wptr == c_wptr_last) ? '0 : r_wptr + c_wptr_step;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_rptr_last) ? '0 : r_rptr + c_rptr_step;
      end
      // Modular add/subtract covers all four push/pop combinations; the true
      // result is always within 0..MEM_SIZE.
      r_cnt <= r_cnt + (w_push ? c_cnt_wstep : '0) - (w_pop ? c_cnt_rstep : '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buffer2_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_buffer2_stream_ctrl                                         |
// | Purpose : Self-checking bench for buffer2_stream_ctrl with a behavioural |
// |           line buffer and a word-level scoreboard of the stream.         |
// | Config  : BUF2_CTRL_FLUSH_EN - when defined, flush is also exercised.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_buffer2_stream_ctrl;

  localparam int SIZE = 16;
  localparam int MEM  = 8;
  localparam int PW   = 4;
  localparam int PR   = 2;
  localparam int AW   = 3;
  localparam int CW   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SIZE*PW-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SIZE*PR-1:0] out_data;
  logic              buf_wen;
  logic [AW-1:0]     buf_waddr;
  logic [SIZE*PW-1:0] buf_din;
  logic [AW-1:0]     buf_raddr;
  logic [SIZE*PR-1:0] buf_dout;
  logic [CW-1:0]     count;

  int n_cmp = 0;
  int n_err = 0;

  logic [SIZE-1:0] sb[$];
  logic [SIZE-1:0] mem[MEM];

  buffer2_stream_ctrl #(
    .SIZE(SIZE), .MEM_SIZE(MEM), .PAR_WRITE(PW), .PAR_READ(PR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef BUF2_CTRL_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .buf_wen   (buf_wen),
    .buf_waddr (buf_waddr),
    .buf_din   (buf_din),
    .buf_raddr (buf_raddr),
    .buf_dout  (buf_dout),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Behavioural line buffer: registered parallel write, combinational read.
  always @(posedge clk) begin
    if (buf_wen) begin
      for (int k = 0; k < PW; k++) mem[(int'(buf_waddr) + k) % MEM] <= buf_din[k*SIZE +: SIZE];
    end
  end

  always_comb begin
    buf_dout = '0;
    for (int j = 0; j < PR; j++) buf_dout[j*SIZE +: SIZE] = mem[(int'(buf_raddr) + j) % MEM];
  end

  // Stream scoreboard: words are queued when a beat is accepted and compared
  // when the downstream beat is consumed. Sampled mid-cycle, inputs stable.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        for (int j = 0; j < PR; j++) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow: got word %0h with nothing expected", out_data[j*SIZE +: SIZE]);
          end else begin
            logic [SIZE-1:0] exp_w;
            exp_w = sb.pop_front();
            if (out_data[j*SIZE +: SIZE] !== exp_w) begin
              n_err++;
              $display("FAIL sb_word%0d: got %0h expected %0h", j, out_data[j*SIZE +: SIZE], exp_w);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        for (int k = 0; k < PW; k++) sb.push_back(in_data[k*SIZE +: SIZE]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
    n_cmp++; if (buf_raddr !== 3'd0) begin n_err++; $display("FAIL rst_raddr: got %0d expected 0", buf_raddr); end
    n_cmp++; if (buf_waddr !== 3'd0) begin n_err++; $display("FAIL rst_waddr: got %0d expected 0", buf_waddr); end
    n_cmp++; if (buf_wen !== 1'b0) begin n_err++; $display("FAIL rst_wen: got %0b expected 0", buf_wen); end
  endtask

  task automatic test_first_push();
    in_valid = 1'b1;
    in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    #1;
    n_cmp++; if (buf_wen !== 1'b1) begin n_err++; $display("FAIL push1_wen: got %0b expected 1", buf_wen); end
    n_cmp++; if (buf_waddr !== 3'd0) begin n_err++; $display("FAIL push1_waddr: got %0d expected 0", buf_waddr); end
    // Empty boundary: the landing push must not make out_valid visible yet.
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL push1_no_bypass: got %0b expected 0", out_valid); end
    n_cmp++; if (buf_din !== in_data) begin n_err++; $display("FAIL push1_din: got %0h expected %0h", buf_din, in_data); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL push1_count: got %0d expected 4", count); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL push1_out_valid: got %0b expected 1", out_valid); end
    n_cmp++; if (out_data !== 32'h0002_0001) begin n_err++; $display("FAIL push1_out_data: got %0h expected 20001", out_data); end
  endtask

  task automatic test_fill();
    in_valid = 1'b1;
    in_data  = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
    #1;
    n_cmp++; if (buf_waddr !== 3'd4) begin n_err++; $display("FAIL fill_waddr: got %0d expected 4", buf_waddr); end
    tick();
    in_data = {16'h000c, 16'h000b, 16'h000a, 16'h0009};
    #1;
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count: got %0d expected 8", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready: got %0b expected 0", in_ready); end
    n_cmp++; if (buf_wen !== 1'b0) begin n_err++; $display("FAIL fill_wen_held: got %0b expected 0", buf_wen); end
    tick();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count_hold: got %0d expected 8", count); end
  endtask

  task automatic test_drain_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (buf_raddr !== 3'(2*i)) begin n_err++; $display("FAIL drain_raddr%0d: got %0d expected %0d", i, buf_raddr, 2*i); end
      tick();
    end
    out_ready = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL drain_count: got %0d expected 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_out_valid: got %0b expected 0", out_valid); end
    in_valid = 1'b1;
    in_data  = {16'h0010, 16'h000f, 16'h000e, 16'h000d};
    #1;
    n_cmp++; if (buf_waddr !== 3'd0) begin n_err++; $display("FAIL wrap_waddr: got %0d expected 0", buf_waddr); end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (buf_raddr !== 3'd0) begin n_err++; $display("FAIL wrap_raddr: got %0d expected 0", buf_raddr); end
    tick();
    tick();
    out_ready = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL wrap_count: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    // Pointers here: wptr=4, rptr=4.
    in_valid = 1'b1;
    in_data  = {16'h0014, 16'h0013, 16'h0012, 16'h0011};
    tick();
    in_data   = {16'h0018, 16'h0017, 16'h0016, 16'h0015};
    out_ready = 1'b1;
    #1;
    n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL b2b_count4: got %0d expected 4", count); end
    n_cmp++; if (buf_wen !== 1'b1) begin n_err++; $display("FAIL b2b_wen: got %0b expected 1", buf_wen); end
    tick();
    in_data = {16'h001c, 16'h001b, 16'h001a, 16'h0019};
    #1;
    n_cmp++; if (count !== 4'd6) begin n_err++; $display("FAIL b2b_count6: got %0d expected 6", count); end
    n_cmp++; if (buf_waddr !== 3'd4) begin n_err++; $display("FAIL b2b_waddr: got %0d expected 4", buf_waddr); end
    n_cmp++; if (buf_raddr !== 3'd6) begin n_err++; $display("FAIL b2b_raddr: got %0d expected 6", buf_raddr); end
    // Full boundary: the simultaneous pop does not make room this cycle.
    n_cmp++; if (buf_wen !== 1'b0) begin n_err++; $display("FAIL b2b_full_wen: got %0b expected 0", buf_wen); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_out_valid: got %0b expected 1", out_valid); end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL b2b_count_after: got %0d expected 4", count); end
    n_cmp++; if (buf_raddr !== 3'd0) begin n_err++; $display("FAIL b2b_raddr_wrap: got %0d expected 0", buf_raddr); end
  endtask

  task automatic test_rst_midop();
    in_valid = 1'b1;
    in_data  = {16'hdead, 16'hdead, 16'hdead, 16'hdead};
    rst      = 1'b1;
    #1;
    n_cmp++; if (buf_wen !== 1'b0) begin n_err++; $display("FAIL rstmid_wen: got %0b expected 0", buf_wen); end
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    n_cmp++; if (buf_waddr !== 3'd0) begin n_err++; $display("FAIL rstmid_waddr: got %0d expected 0", buf_waddr); end
    n_cmp++; if (buf_raddr !== 3'd0) begin n_err++; $display("FAIL rstmid_raddr: got %0d expected 0", buf_raddr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %0b expected 0", out_valid); end
  endtask

`ifdef BUF2_CTRL_FLUSH_EN
  task automatic test_flush();
    in_valid = 1'b1;
    in_data  = {16'h0024, 16'h0023, 16'h0022, 16'h0021};
    tick();
    in_data   = {16'h0028, 16'h0027, 16'h0026, 16'h0025};
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_data   = {16'hbeef, 16'hbeef, 16'hbeef, 16'hbeef};
    #1;
    n_cmp++; if (count !== 4'd6) begin n_err++; $display("FAIL flush_pre_count: got %0d expected 6", count); end
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    n_cmp++; if (buf_wen !== 1'b0) begin n_err++; $display("FAIL flush_wen: got %0b expected 0", buf_wen); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %0b expected 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %0b expected 0", out_valid); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", count); end
    n_cmp++; if (buf_waddr !== 3'd0) begin n_err++; $display("FAIL flush_waddr: got %0d expected 0", buf_waddr); end
  endtask
`endif

  task automatic test_random_stream();
    int model_cnt;
    bit exp_push;
    bit exp_pop;
    model_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      #1;
      exp_push = in_valid && (model_cnt <= MEM - PW);
      exp_pop  = out_ready && (model_cnt >= PR);
      n_cmp++; if (count !== 4'(model_cnt)) begin n_err++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, count, model_cnt); end
      n_cmp++; if (buf_wen !== exp_push) begin n_err++; $display("FAIL rnd_wen c%0d: got %0b expected %0b", c, buf_wen, exp_push); end
      n_cmp++; if (out_valid !== (model_cnt >= PR)) begin n_err++; $display("FAIL rnd_out_valid c%0d: got %0b expected %0b", c, out_valid, model_cnt >= PR); end
      tick();
      model_cnt = model_cnt + (exp_push ? PW : 0) - (exp_pop ? PR : 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8 && count >= 4'd2; c++) tick();
    out_ready = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rnd_drain_count: got %0d expected 0", count); end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL rnd_sb_left: got %0d words expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_fill();
    test_drain_wrap();
    test_back_to_back();
    test_rst_midop();
`ifdef BUF2_CTRL_FLUSH_EN
    test_flush();
`endif
    test_random_stream();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
